// File: rtl/bh_pkg.sv
// Shared constants, FSM states and next-Q helper
// for the BH flip-flop command sequencer.
package bh_pkg;

  localparam logic [1:0] BH_TOGGLE = 2'b00;
  localparam logic [1:0] BH_SET1   = 2'b01;
  localparam logic [1:0] BH_SET0   = 2'b10;
  localparam logic [1:0] BH_HOLD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic bh_next(
    input logic q,
    input logic b,
    input logic h
  );
    logic r;
    unique case ({b, h})
      BH_TOGGLE: r = ~q;
      BH_SET1:   r = 1'b1;
      BH_SET0:   r = 1'b0;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bh_cmd_sequencer_if.sv
// Command valid/ready bundle between the
// command source and the BH sequencer.
interface bh_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);

  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] count;

  modport master (
    output valid, op, mask, count,
    input  ready
  );

  modport slave (
    input  valid, op, mask, count,
    output ready
  );

endinterface

// File: rtl/bh_cmd_fifo.sv
// Small synchronous FIFO with wrap-bit pointers
// holding queued sequencer commands.
module bh_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_push;
  logic          do_pop;

  assign full = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign dout = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bh_cmd_sequencer.sv
// Replays queued per-lane BH commands onto the B/H
// lines and tracks the expected flip-flop bank Q.
module bh_cmd_sequencer
  import bh_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bh_cmd_sequencer_if.slave cmd,
  output logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  H,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  q_model
);

  localparam int DW = 2 + WIDTH + CNT_W;

  logic [DW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_mask;
  logic [CNT_W-1:0] head_cnt;
  logic [WIDTH-1:0] enc_b;
  logic [WIDTH-1:0] enc_h;

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] h_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;

  assign cmd.ready = !full;
  assign push      = cmd.valid && !full;
  assign {head_op, head_mask, head_cnt} = head;

  // Head leaves the FIFO exactly when the FSM loads it.
  assign pop = !empty &&
               ((state_q == ST_IDLE) || (rem_q == '0));

  bh_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({cmd.op, cmd.mask, cmd.count}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    enc_b = '1;
    enc_h = '1;
    for (int i = 0; i < WIDTH; i++) begin
      if (head_mask[i]) begin
        enc_b[i] = head_op[1];
        enc_h[i] = head_op[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      b_q     <= '1;
      h_q     <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '1;
    end else begin
      done_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        q_q[i] <= bh_next(q_q[i], b_q[i], h_q[i]);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            b_q     <= enc_b;
            h_q     <= enc_h;
            rem_q   <= head_cnt;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            b_q <= {WIDTH{BH_HOLD[1]}};
            h_q <= {WIDTH{BH_HOLD[0]}};
          end
        end
        ST_RUN: begin
          if (rem_q != '0) begin
            rem_q <= rem_q - CNT_W'(1);
          end else if (!empty) begin
            b_q   <= enc_b;
            h_q   <= enc_h;
            rem_q <= head_cnt;
          end else begin
            b_q     <= {WIDTH{BH_HOLD[1]}};
            h_q     <= {WIDTH{BH_HOLD[0]}};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign B       = b_q;
  assign H       = h_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign q_model = q_q;

endmodule

// File: tb/tb_bh_cmd_sequencer.sv
// Self-checking bench: vector table plus a beat
// scoreboard that predicts B/H/busy/done/Q per cycle.
module tb_bh_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bh_cmd_sequencer_if #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) cif ();

  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] H;
  logic [WIDTH-1:0] q_model;
  logic             busy;
  logic             done;

  bh_cmd_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cif),
    .B       (B),
    .H       (H),
    .busy    (busy),
    .done    (done),
    .q_model (q_model)
  );

  typedef struct {
    logic [1:0] b_h_unused;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] h;
    int avail;
    bit first;
  } beat_t;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] q;
  } vec_t;

  beat_t            beats[$];
  beat_t            bt;
  logic [WIDTH-1:0] exp_b = '1;
  logic [WIDTH-1:0] exp_h = '1;
  logic [WIDTH-1:0] exp_q = '1;
  bit               exp_busy = 1'b0;
  bit               exp_done = 1'b0;
  bit               was_busy;
  bit               acc;
  bit               acc_seen = 1'b0;
  bit               chk_en = 1'b0;
  int               pending = 0;
  int               edge_n = 0;
  int               checks = 0;
  int               errors = 0;
  int               busy_cycles = 0;
  int               ready_low = 0;
  logic [1:0]       lb;
  vec_t             tv[7];

  function automatic logic [1:0] lane_bh(
    input logic [1:0] op,
    input logic       m
  );
    return m ? op : 2'b11;
  endfunction

  function automatic logic next_q(
    input logic q,
    input logic b,
    input logic h
  );
    if (b && h) return q;
    if (b)      return 1'b0;
    if (h)      return 1'b1;
    return ~q;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: a stream of expected beats per command.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        beats.delete();
        exp_b    = '1;
        exp_h    = '1;
        exp_q    = '1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        pending  = 0;
      end else begin
        acc = cif.valid && (pending < DEPTH);
        for (int i = 0; i < WIDTH; i++)
          exp_q[i] = next_q(exp_q[i], exp_b[i], exp_h[i]);
        was_busy = exp_busy;
        if (beats.size() > 0 && beats[0].avail <= edge_n) begin
          bt = beats.pop_front();
          exp_b = bt.b;
          exp_h = bt.h;
          exp_busy = 1'b1;
          if (bt.first) pending--;
        end else begin
          exp_b = '1;
          exp_h = '1;
          exp_busy = 1'b0;
        end
        exp_done = was_busy && !exp_busy;
        if (acc) begin
          for (int k = 0; k <= int'(cif.count); k++) begin
            for (int i = 0; i < WIDTH; i++) begin
              lb = lane_bh(cif.op, cif.mask[i]);
              bt.b[i] = lb[1];
              bt.h[i] = lb[0];
            end
            bt.b_h_unused = 2'b00;
            bt.avail = edge_n + 1;
            bt.first = (k == 0);
            beats.push_back(bt);
          end
          pending++;
          acc_seen = 1'b1;
        end
        edge_n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (!cif.ready) ready_low++;
      if (chk_en) begin
        chk("B", 32'(B), 32'(exp_b));
        chk("H", 32'(H), 32'(exp_h));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("q_model", 32'(q_model), 32'(exp_q));
        chk("ready", 32'(cif.ready),
            32'(pending < DEPTH));
      end
    end
  end

  task automatic send(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] m,
    input logic [CNT_W-1:0] c
  );
    int n;
    cif.valid = 1'b1;
    cif.op    = op;
    cif.mask  = m;
    cif.count = c;
    acc_seen  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_seen && n < 100);
    chk("accept_timeout", 32'(acc_seen), 32'd1);
    cif.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_busy || pending != 0 ||
            beats.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.valid = 1'b0;
    cif.op    = 2'b11;
    cif.mask  = '0;
    cif.count = '0;

    tv[0] = '{2'b00, 4'b0101, 4'd2,
              4'b1010, 4'b1010, 4'b1010};
    tv[1] = '{2'b10, 4'b1111, 4'd0,
              4'b1111, 4'b0000, 4'b0000};
    tv[2] = '{2'b01, 4'b0011, 4'd1,
              4'b1100, 4'b1111, 4'b0011};
    tv[3] = '{2'b10, 4'b1100, 4'd0,
              4'b1111, 4'b0011, 4'b0011};
    tv[4] = '{2'b11, 4'b1111, 4'd0,
              4'b1111, 4'b1111, 4'b0011};
    tv[5] = '{2'b01, 4'b1000, 4'd15,
              4'b0111, 4'b1111, 4'b1011};
    tv[6] = '{2'b00, 4'b1111, 4'd1,
              4'b0000, 4'b0000, 4'b1011};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_B", 32'(B), 32'hF);
    chk("rst_H", 32'(H), 32'hF);
    chk("rst_q", 32'(q_model), 32'hF);
    chk("rst_ready", 32'(cif.ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(tv[i].op, tv[i].mask, tv[i].count);
      @(negedge clk);
      chk("tv_B", 32'(B), 32'(tv[i].b));
      chk("tv_H", 32'(H), 32'(tv[i].h));
      wait_idle();
      chk("tv_q", 32'(q_model), 32'(tv[i].q));
    end

    // Back-to-back commands from an all-zero bank.
    send(2'b10, 4'b1111, 4'd0);
    wait_idle();
    chk("b2b_q0", 32'(q_model), 32'h0);
    busy_cycles = 0;
    send(2'b01, 4'b0011, 4'd1);
    send(2'b10, 4'b1100, 4'd0);
    wait_idle();
    chk("b2b_q", 32'(q_model), 32'h3);
    chk("b2b_busy", 32'(busy_cycles), 32'd3);

    // Six pushes with valid held; FIFO fills.
    busy_cycles = 0;
    ready_low = 0;
    for (int i = 0; i < 6; i++) begin
      send(2'b00, 4'(1 << (i % 4)), 4'd3);
    end
    wait_idle();
    chk("full_busy", 32'(busy_cycles), 32'd24);
    chk("full_ready_low", 32'(ready_low != 0), 32'd1);
    chk("full_q", 32'(q_model), 32'h3);

    // Asynchronous reset in the second run cycle.
    send(2'b00, 4'b1111, 4'd5);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_B", 32'(B), 32'hF);
    chk("mid_H", 32'(H), 32'hF);
    chk("mid_q", 32'(q_model), 32'hF);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_B", 32'(B), 32'hF);
    end
    chk("post_q", 32'(q_model), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
